multicycle_processor: RTL and testbench
=======================================

Name: multicycle_processor

Overview:
- Parametrised multicycle successor to the single-cycle 8-bit core.
- Fetches one instruction per handshake and sequences it through FETCH/EXEC/MEM/WB.
- Register file width/count, PC width and data-memory depth are parameters; contains its own data memory plus an external preload port.
- Writeback value and register index are exported for the seven-segment display logic and the bench.

Parameters:
- DATA_WIDTH, 8, register/ALU/memory word width
- REG_ADDR_W, 2, register index width; REG_COUNT = 2**REG_ADDR_W; INSTR_W = 2 + 3*REG_ADDR_W
- PC_WIDTH, 8, program counter width
- MEM_ADDR_W, 4, data memory depth = 2**MEM_ADDR_W words

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- instr  input  INSTR_W  instruction word: op[top 2], rs, rt, rd/imm (each REG_ADDR_W)
- instr_valid  input  1  instr is valid
- instr_ready  output  1  core accepts instr this cycle
- pc  output  PC_WIDTH  address of instruction to fetch
- mem_load_en  input  1  external data-memory write strobe
- mem_load_addr  input  MEM_ADDR_W  preload address
- mem_load_data  input  DATA_WIDTH  preload data
- wb_valid  output  1  one-cycle pulse: register written
- wb_reg  output  REG_ADDR_W  destination register of the write
- wb_data  output  DATA_WIDTH  value written
- retire  output  1  one-cycle pulse per completed instruction
- instr_count  output  16  retired-instruction counter

Behaviour:
- Reset (reset low, asynchronous): state=FETCH; pc, all registers, all memory words, IR, wb_reg, wb_data, instr_count = 0; wb_valid = retire = 0. Reset during any state aborts the instruction; no partial register/memory write survives.
- imm = rd/imm field sign-extended to DATA_WIDTH (ALU) and PC_WIDTH (branch).
- Ops: 00 ADD R[rd]=R[rs]+R[rt]; 01 LW R[rt]=M[R[rs]+imm]; 10 SW M[R[rs]+imm]=R[rt]; 11 BR pc=pc+1+imm.
- Memory address = low MEM_ADDR_W bits of the ALU result; upper bits ignored.
- Arithmetic wraps modulo 2**DATA_WIDTH; pc wraps modulo 2**PC_WIDTH.
- FETCH: instr_ready=1. On instr_valid, latch IR, go to EXEC. Otherwise stay; pc held.
- EXEC: read R[rs], R[rt]; latch ALU result and branch decision. ADD/BR -> WB; LW/SW -> MEM.
- MEM: LW latches M[addr]; SW writes M[addr]=R[rt]. Then -> WB.
- WB:
  - ADD/LW: write register; wb_valid=1; wb_reg/wb_data updated and held until the next write.
  - pc = pc+1, or pc+1+imm when a branch is taken.
  - retire=1; instr_count+1 (wraps at 2**16); -> FETCH.
- Latency from accept cycle to retire pulse: ADD/BR 2 cycles, LW/SW 3 cycles. instr_ready is low from EXEC through WB.
- Register write in WB is visible to the EXEC of the next instruction (no hazards, single issue).
- mem_load port: writes M[mem_load_addr] in any cycle. If it coincides with a core SW to the same address in MEM, the core write wins. A load to an address an LW reads in the same MEM cycle returns the old value.
- Register 0 is an ordinary writable register.

Optional Feature:
- Macro COND_BRANCH_EN.
- Defined: op 11 branches only when R[rs]==R[rt]; otherwise pc=pc+1.
- Undefined: op 11 always branches; rs/rt ignored.
- Latency is identical in both builds.

Test Plan:
- Preload M[1]=0x05; LW 0x45 -> wb_valid with wb_reg=1, wb_data=0x05, 3 cycles after accept; pc 0->1; instr_count=1.
- ADD 0x16 (r2=r1+r1) -> wb_reg=2, wb_data=0x0A, retire 2 cycles after accept; SW 0x8A then LW 0x4E -> wb_reg=3, wb_data=0x0A; no wb_valid on the SW.
- Preload M[1]=0xFF, LW r1, ADD 0x16 -> wb_data=0xFE (wrap). BR 0xC3 at pc=0xFF -> pc stays 0xFF; BR 0xC1 at pc=0xFF -> pc=0x01.
- instr_valid low for 5 cycles in FETCH -> instr_ready held 1, pc unchanged, no retire/wb_valid, instr_count unchanged.
- Assert reset low during MEM of SW to M[2] -> M[2]=0, pc=0, regs 0, state FETCH immediately (asynchronous), instr_count=0.
- COND_BRANCH_EN with r0=0, r1=5: 0xD1 at pc=4 -> pc=5 (not taken); 0xC1 at pc=5 -> pc=7 (taken). Without the macro, 0xD1 -> pc=6.

Source files
------------

// File: rtl/multicycle_processor.sv
// multicycle_processor: parametrised multicycle core.
// Each instruction is accepted by a valid/ready handshake in FETCH and then
// runs through EXEC, MEM (LW/SW only) and WB. The data memory sits inside the
// core and can also be written from outside through the mem_load port.
// Architectural state (registers, pc, instr_count, wb_reg/wb_data) is updated
// on the clock edge that enters WB. As a result, every WB-cycle output
// (wb_valid, retire, pc, instr_count, wb_data) already shows the finished
// instruction.
// Optional feature: define COND_BRANCH_EN to make op 11 branch only when
// R[rs] == R[rt]. Without it, op 11 always branches. Latency is the same in
// both builds.
module multicycle_processor #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_ADDR_W = 2,
    parameter int PC_WIDTH   = 8,
    parameter int MEM_ADDR_W = 4,
    localparam int REG_COUNT = 2**REG_ADDR_W,
    localparam int INSTR_W   = 2 + 3*REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [PC_WIDTH-1:0]   pc,
    input  logic                  mem_load_en,
    input  logic [MEM_ADDR_W-1:0] mem_load_addr,
    input  logic [DATA_WIDTH-1:0] mem_load_data,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  retire,
    output logic [15:0]           instr_count,
    output logic [1:0]            dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid
    // and instr_ready are both high. instr_ready is high only in FETCH, and
    // instr is sampled only on that edge.

    localparam int MEM_DEPTH = 2**MEM_ADDR_W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t state, next_state;

    logic [INSTR_W-1:0]    ir;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] mem  [MEM_DEPTH];

    logic [1:0]            op;
    logic [REG_ADDR_W-1:0] rs_f, rt_f, rd_f;
    logic [DATA_WIDTH-1:0] imm_d;
    logic [PC_WIDTH-1:0]   imm_p;
    logic [DATA_WIDTH-1:0] rs_val, rt_val;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  br_taken;

    logic [MEM_ADDR_W-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] sw_data_q;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  commit;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_val;
    logic [PC_WIDTH-1:0]   br_off;
    logic [PC_WIDTH-1:0]   pc_next;

    // Instruction fields: op | rs | rt | rd/imm
    assign op   = ir[INSTR_W-1 -: 2];
    assign rs_f = ir[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rt_f = ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rd_f = ir[REG_ADDR_W-1:0];

    assign imm_d = {{(DATA_WIDTH-REG_ADDR_W){rd_f[REG_ADDR_W-1]}}, rd_f};
    assign imm_p = {{(PC_WIDTH-REG_ADDR_W){rd_f[REG_ADDR_W-1]}}, rd_f};

    assign rs_val    = regs[rs_f];
    assign rt_val    = regs[rt_f];
    // LW reads the array during MEM. A same-cycle preload lands at the edge,
    // so the LW sees the old word.
    assign mem_rdata = mem[mem_addr_q];

`ifdef COND_BRANCH_EN
    assign br_taken = (rs_val == rt_val);
`else
    assign br_taken = 1'b1;
`endif

    // ALU: ADD sums the two registers; every other op forms base + imm.
    always_comb begin
        alu_res = rs_val + imm_d;
        if (op == OP_ADD) begin
            alu_res = rs_val + rt_val;
        end
    end

    // Commit control: ADD/BR commit on leaving EXEC, LW/SW on leaving MEM.
    always_comb begin
        commit    = ((state == S_EXEC) && ((op == OP_ADD) || (op == OP_BR)))
                    || (state == S_MEM);
        reg_write = commit && ((op == OP_ADD) || (op == OP_LW));
        wr_idx    = (op == OP_ADD) ? rd_f : rt_f;
        wr_val    = (state == S_MEM) ? mem_rdata : alu_res;
        br_off    = ((state == S_EXEC) && (op == OP_BR) && br_taken) ? imm_p : '0;
        pc_next   = pc + PC_WIDTH'(1) + br_off;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: if (instr_valid) next_state = S_EXEC;
            S_EXEC:  next_state = ((op == OP_LW) || (op == OP_SW)) ? S_MEM : S_WB;
            S_MEM:   next_state = S_WB;
            S_WB:    next_state = S_FETCH;
            default: next_state = S_FETCH;
        endcase
    end

    // FSM outputs: handshake, WB-cycle pulses and state visibility
    always_comb begin
        instr_ready = (state == S_FETCH);
        retire      = (state == S_WB);
        wb_valid    = (state == S_WB) && ((op == OP_ADD) || (op == OP_LW));
        dbg_state   = state;
    end

    // Instruction, EXEC latches, pc, counter and writeback view
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir          <= '0;
            mem_addr_q  <= '0;
            sw_data_q   <= '0;
            pc          <= '0;
            instr_count <= '0;
            wb_reg      <= '0;
            wb_data     <= '0;
        end else begin
            if ((state == S_FETCH) && instr_valid) begin
                ir <= instr;
            end
            if (state == S_EXEC) begin
                mem_addr_q <= alu_res[MEM_ADDR_W-1:0];
                sw_data_q  <= rt_val;
            end
            if (commit) begin
                pc          <= pc_next;
                instr_count <= instr_count + 16'd1;
            end
            if (reg_write) begin
                wb_reg  <= wr_idx;
                wb_data <= wr_val;
            end
        end
    end

    // Register file: one write port, used at commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write) begin
            regs[wr_idx] <= wr_val;
        end
    end

    // Data memory: external preload, then the core SW (later assignment wins)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (mem_load_en) begin
                mem[mem_load_addr] <= mem_load_data;
            end
            if ((state == S_MEM) && (op == OP_SW)) begin
                mem[mem_addr_q] <= sw_data_q;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_processor.sv
// Bench for multicycle_processor. It issues directed instructions with
// hand-computed results. A monitor compares every writeback and retire
// against the expected queues.
module tb_multicycle_processor;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] pc;
    logic       mem_load_en;
    logic [3:0] mem_load_addr;
    logic [7:0] mem_load_data;
    logic       wb_valid;
    logic [1:0] wb_reg;
    logic [7:0] wb_data;
    logic       retire;
    logic [15:0] instr_count;
    logic [1:0] dbg_state;

    multicycle_processor dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc           (pc),
        .mem_load_en  (mem_load_en),
        .mem_load_addr(mem_load_addr),
        .mem_load_data(mem_load_data),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .retire       (retire),
        .instr_count  (instr_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [9:0]  exp_wb_q[$];   // {reg, data}
    logic [23:0] exp_ret_q[$];  // {pc, instr_count}
    int          exp_cyc_q[$];  // cycle the retire pulse must appear in
    logic [15:0] exp_count = 16'd0;
    logic [7:0]  exp_pc    = 8'd0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [9:0]  mon_wb;
    logic [23:0] mon_ret;
    int          mon_cyc;

    always @(negedge clk) begin
        if (reset) begin
            if (wb_valid) begin
                if (exp_wb_q.size() == 0) begin
                    chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
                end else begin
                    mon_wb = exp_wb_q.pop_front();
                    chk("wb_reg", 32'(wb_reg), 32'(mon_wb[9:8]));
                    chk("wb_data", 32'(wb_data), 32'(mon_wb[7:0]));
                end
            end
            if (retire) begin
                if (exp_ret_q.size() == 0) begin
                    chk("unexpected_retire", 32'(retire), 32'd0);
                end else begin
                    mon_ret = exp_ret_q.pop_front();
                    mon_cyc = exp_cyc_q.pop_front();
                    chk("retire_pc", 32'(pc), 32'(mon_ret[23:16]));
                    chk("instr_count", 32'(instr_count), 32'(mon_ret[15:0]));
                    chk("retire_latency", 32'(cyc), 32'(mon_cyc));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        mem_load_en   = 1'b1;
        mem_load_addr = a;
        mem_load_data = d;
        @(negedge clk);
        mem_load_en   = 1'b0;
    endtask

    // Issue one instruction. If ld_en is set, a preload is driven during
    // the instruction's MEM cycle.
    task automatic issue(input logic [7:0] w, input int lat, input logic has_wb,
                         input logic [1:0] r, input logic [7:0] d, input logic [7:0] p,
                         input logic ld_en, input logic [3:0] ld_a, input logic [7:0] ld_d);
        int waited;
        waited = 0;
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        exp_count = exp_count + 16'd1;
        exp_pc    = p;
        if (has_wb) exp_wb_q.push_back({r, d});
        exp_ret_q.push_back({p, exp_count});
        exp_cyc_q.push_back(cyc + lat);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        if (ld_en) begin
            @(negedge clk);          // EXEC
            @(negedge clk);          // MEM
            mem_load_en   = 1'b1;
            mem_load_addr = ld_a;
            mem_load_data = ld_d;
            @(negedge clk);
            mem_load_en   = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_ret_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("retire_timeout", 32'(exp_ret_q.size()), 32'd0);
        chk("wb_pending", 32'(exp_wb_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] pc_d1;
    int         n_br;
    int         n_wait;

    initial begin
`ifdef COND_BRANCH_EN
        pc_d1 = 8'd5;
`else
        pc_d1 = 8'd6;
`endif
        reset         = 1'b0;
        instr         = 8'h00;
        instr_valid   = 1'b0;
        mem_load_en   = 1'b0;
        mem_load_addr = 4'h0;
        mem_load_data = 8'h00;
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr_count", 32'(instr_count), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // LW / ADD / SW / LW
        preload(4'd1, 8'h05);
        issue(8'h45, 3, 1'b1, 2'd1, 8'h05, 8'd1, 1'b0, 4'd0, 8'd0); wait_idle();
        issue(8'h16, 2, 1'b1, 2'd2, 8'h0A, 8'd2, 1'b0, 4'd0, 8'd0); wait_idle();
        issue(8'h8A, 3, 1'b0, 2'd0, 8'h00, 8'd3, 1'b0, 4'd0, 8'd0); wait_idle();
        issue(8'h4E, 3, 1'b1, 2'd3, 8'h0A, 8'd4, 1'b0, 4'd0, 8'd0); wait_idle();

        // Branches with r0=0, r1=5
        issue(8'hD1, 2, 1'b0, 2'd0, 8'h00, pc_d1, 1'b0, 4'd0, 8'd0); wait_idle();
        issue(8'hC1, 2, 1'b0, 2'd0, 8'h00, pc_d1 + 8'd2, 1'b0, 4'd0, 8'd0); wait_idle();

        // Idle FETCH: no handshake, nothing moves
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("idle_ready", 32'(instr_ready), 32'd1);
            chk("idle_pc", 32'(pc), 32'(exp_pc));
            chk("idle_count", 32'(instr_count), 32'(exp_count));
            @(negedge clk);
        end

        // Data wrap: 0xFF + 0xFF = 0xFE
        preload(4'd1, 8'hFF);
        issue(8'h45, 3, 1'b1, 2'd1, 8'hFF, exp_pc + 8'd1, 1'b0, 4'd0, 8'd0); wait_idle();
        issue(8'h16, 2, 1'b1, 2'd2, 8'hFE, exp_pc + 8'd1, 1'b0, 4'd0, 8'd0); wait_idle();

        // Walk pc up to 0xFF with branches on r0==r0
        n_br = 0;
        while (exp_pc != 8'hFF && n_br < 200) begin
            if ((8'hFF - exp_pc) >= 8'd2)
                issue(8'hC1, 2, 1'b0, 2'd0, 8'h00, exp_pc + 8'd2, 1'b0, 4'd0, 8'd0);
            else
                issue(8'hC0, 2, 1'b0, 2'd0, 8'h00, exp_pc + 8'd1, 1'b0, 4'd0, 8'd0);
            wait_idle();
            n_br++;
        end
        issue(8'hC3, 2, 1'b0, 2'd0, 8'h00, 8'hFF, 1'b0, 4'd0, 8'd0); wait_idle();
        issue(8'hC1, 2, 1'b0, 2'd0, 8'h00, 8'h01, 1'b0, 4'd0, 8'd0); wait_idle();

        // Preload racing core memory traffic on M[14]
        issue(8'h8A, 3, 1'b0, 2'd0, 8'h00, 8'h02, 1'b1, 4'd14, 8'h77); wait_idle();
        issue(8'h4E, 3, 1'b1, 2'd3, 8'hFE, 8'h03, 1'b1, 4'd14, 8'h55); wait_idle();
        issue(8'h4E, 3, 1'b1, 2'd3, 8'h55, 8'h04, 1'b0, 4'd0, 8'd0); wait_idle();

        // Reset during MEM of SW to M[2]
        preload(4'd1, 8'h01);
        preload(4'd2, 8'h33);
        issue(8'h45, 3, 1'b1, 2'd1, 8'h01, 8'h05, 1'b0, 4'd0, 8'd0); wait_idle();
        @(negedge clk);
        instr       = 8'h95;
        instr_valid = 1'b1;
        n_wait = 0;
        while (!instr_ready && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        n_wait = 0;
        while (dbg_state != 2'd2 && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        chk("reach_mem", 32'(dbg_state), 32'd2);
        reset = 1'b0;
        #1;
        chk("async_state", 32'(dbg_state), 32'd0);
        chk("async_pc", 32'(pc), 32'd0);
        chk("async_count", 32'(instr_count), 32'd0);
        chk("async_wb_data", 32'(wb_data), 32'd0);
        chk("async_ready", 32'(instr_ready), 32'd1);
        exp_count = 16'd0;
        exp_pc    = 8'd0;
        @(negedge clk);
        reset = 1'b1;

        // Registers and memory are cleared
        issue(8'h17, 2, 1'b1, 2'd3, 8'h00, 8'h01, 1'b0, 4'd0, 8'd0); wait_idle();
        preload(4'd1, 8'h02);
        issue(8'h45, 3, 1'b1, 2'd1, 8'h02, 8'h02, 1'b0, 4'd0, 8'd0); wait_idle();
        issue(8'h58, 3, 1'b1, 2'd2, 8'h00, 8'h03, 1'b0, 4'd0, 8'd0); wait_idle();
        issue(8'h4E, 3, 1'b1, 2'd3, 8'h00, 8'h04, 1'b0, 4'd0, 8'd0); wait_idle();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
